// File: rtl/handle_remote_shift.sv
// Receive-side shift handler: tracks the opponent's selected card group and
// replays their one-column moves onto the shared table RAM, one slot per cycle.
module handle_remote_shift #(
   parameter logic [3:0] MSG_SHIFT_SEL  = 4'd6,
   parameter logic [3:0] MSG_SHIFT_MOVE = 4'd7,
   parameter logic [3:0] MSG_SHIFT_DONE = 4'd8,
   parameter logic [3:0] ST_OPP_SHIFT   = 4'd5,
   parameter logic [5:0] EMPTY_CARD     = 6'd63
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           interboard_rst,
   input  logic           interboard_en,
   input  logic [3:0]     interboard_msg_type,
   input  logic           interboard_move_dir,
   input  logic [4:0]     interboard_block_x,
   input  logic [2:0]     interboard_block_y,
   input  logic [2:0]     interboard_sel_len,
   input  logic [3:0]     cur_game_state,
   output logic [4:0]     tbl_rd_x,
   output logic [2:0]     tbl_rd_y,
   input  logic [5:0]     tbl_rd_card,
   output logic           tbl_wr_en,
   output logic [4:0]     tbl_wr_x,
   output logic [2:0]     tbl_wr_y,
   output logic [5:0]     tbl_wr_card,
   output logic           remote_busy,
   output logic           remote_shift_done,
   output logic           remote_shift_err,
   output logic [143:0]   remote_sel_card
);

   // state   | meaning
   // S_IDLE  | waiting for a message from the opponent board
   // S_CHECK | reading the target slot, validating the move
   // S_COPY  | copying one group slot per cycle toward the target
   // S_CLEAR | emptying the vacated slot, updating sel_x
   // S_FIN   | pulsing remote_shift_done
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_COPY  = 3'd2,
      S_CLEAR = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   state_t         state_q, state_d;
   logic [4:0]     sel_x_q, sel_x_d;
   logic [2:0]     sel_y_q, sel_y_d;
   logic [2:0]     sel_len_q, sel_len_d;
   logic           dir_q, dir_d;
   logic [2:0]     rem_q, rem_d;
   logic           err_q, err_d;
   logic [143:0]   mask_q, mask_d;

   logic           rst_any;
   logic           accept;
   logic           sel_valid;
   logic [5:0]     x6, len6, end6, idx6, src6, dst6;
   logic [8:0]     base9, top9;

   assign rst_any = rst | interboard_rst;
   assign accept  = interboard_en && (cur_game_state == ST_OPP_SHIFT) && (state_q == S_IDLE);

   // Column math is kept at 6 bits so x+len past the right edge cannot wrap.
   assign x6   = {1'b0, sel_x_q};
   assign len6 = {3'd0, sel_len_q};
   assign end6 = x6 + len6;
   assign idx6 = dir_q ? ({3'd0, rem_q} - 6'd1) : (len6 - {3'd0, rem_q});
   assign src6 = x6 + idx6;
   assign dst6 = dir_q ? (src6 + 6'd1) : (src6 - 6'd1);

   assign sel_valid = (interboard_sel_len != 3'd0) &&
                      (({1'b0, interboard_block_x} + {3'd0, interboard_sel_len}) <= 6'd18);

   always_comb begin
      state_d     = state_q;
      sel_x_d     = sel_x_q;
      sel_y_d     = sel_y_q;
      sel_len_d   = sel_len_q;
      dir_d       = dir_q;
      rem_d       = rem_q;
      err_d       = 1'b0;
      tbl_rd_x    = 5'd0;
      tbl_rd_y    = 3'd0;
      tbl_wr_en   = 1'b0;
      tbl_wr_x    = 5'd0;
      tbl_wr_y    = 3'd0;
      tbl_wr_card = 6'd0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (interboard_msg_type == MSG_SHIFT_SEL) begin
                  if (sel_valid) begin
                     sel_x_d   = interboard_block_x;
                     sel_y_d   = interboard_block_y;
                     sel_len_d = interboard_sel_len;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (interboard_msg_type == MSG_SHIFT_MOVE) begin
                  if (sel_len_q == 3'd0) begin
                     err_d = 1'b1;
                  end else begin
                     dir_d   = interboard_move_dir;
                     state_d = S_CHECK;
                  end
               end else if (interboard_msg_type == MSG_SHIFT_DONE) begin
                  sel_len_d = 3'd0;
               end
            end
         end

         S_CHECK: begin
            if (dir_q) begin
               if (end6 > 6'd17) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  tbl_rd_x = end6[4:0];
                  tbl_rd_y = sel_y_q;
                  if (tbl_rd_card != EMPTY_CARD) begin
                     err_d   = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     rem_d   = sel_len_q;
                     state_d = S_COPY;
                  end
               end
            end else begin
               if (x6 == 6'd0) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  tbl_rd_x = sel_x_q - 5'd1;
                  tbl_rd_y = sel_y_q;
                  if (tbl_rd_card != EMPTY_CARD) begin
                     err_d   = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     rem_d   = sel_len_q;
                     state_d = S_COPY;
                  end
               end
            end
         end

         S_COPY: begin
            tbl_rd_x    = src6[4:0];
            tbl_rd_y    = sel_y_q;
            tbl_wr_en   = 1'b1;
            tbl_wr_x    = dst6[4:0];
            tbl_wr_y    = sel_y_q;
            tbl_wr_card = tbl_rd_card;
            rem_d       = rem_q - 3'd1;
            if (rem_q == 3'd1) begin
               state_d = S_CLEAR;
            end
         end

         S_CLEAR: begin
            tbl_wr_en   = 1'b1;
            tbl_wr_x    = dir_q ? sel_x_q : (end6[4:0] - 5'd1);
            tbl_wr_y    = sel_y_q;
            tbl_wr_card = EMPTY_CARD;
            sel_x_d     = dir_q ? (sel_x_q + 5'd1) : (sel_x_q - 5'd1);
            state_d     = S_FIN;
         end

         S_FIN: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A reset arriving mid-move must not land one more write in the table.
      if (rst_any) begin
         tbl_wr_en = 1'b0;
      end
   end

   // Mask follows the next-state selection so it is current in the FIN cycle.
   always_comb begin
      base9  = ({6'd0, sel_y_d} * 9'd18) + {4'd0, sel_x_d};
      top9   = base9 + {6'd0, sel_len_d};
      mask_d = '0;
      for (int b = 0; b < 144; b++) begin
         mask_d[b] = (sel_len_d != 3'd0) && (9'(b) >= base9) && (9'(b) < top9);
      end
   end

   always_ff @(posedge clk) begin
      if (rst_any) begin
         state_q   <= S_IDLE;
         sel_x_q   <= 5'd0;
         sel_y_q   <= 3'd0;
         sel_len_q <= 3'd0;
         dir_q     <= 1'b0;
         rem_q     <= 3'd0;
         err_q     <= 1'b0;
         mask_q    <= '0;
      end else begin
         state_q   <= state_d;
         sel_x_q   <= sel_x_d;
         sel_y_q   <= sel_y_d;
         sel_len_q <= sel_len_d;
         dir_q     <= dir_d;
         rem_q     <= rem_d;
         err_q     <= err_d;
         mask_q    <= mask_d;
      end
   end

   assign remote_busy       = (state_q != S_IDLE);
   assign remote_shift_done = (state_q == S_FIN);
   assign remote_shift_err  = err_q;
   assign remote_sel_card   = mask_q;

endmodule

// File: tb/tb_handle_remote_shift.sv
// Bench for handle_remote_shift: directed scenarios plus random traffic checked
// against a table/selection model built from the message rules.
module tb_handle_remote_shift;

   localparam logic [3:0] ST    = 4'd5;
   localparam logic [5:0] EMPTY = 6'd63;
   localparam logic [3:0] T_SEL = 4'd6;
   localparam logic [3:0] T_MOV = 4'd7;
   localparam logic [3:0] T_DON = 4'd8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         interboard_rst = 1'b0;
   logic         interboard_en = 1'b0;
   logic [3:0]   interboard_msg_type = 4'd0;
   logic         interboard_move_dir = 1'b0;
   logic [4:0]   interboard_block_x = 5'd0;
   logic [2:0]   interboard_block_y = 3'd0;
   logic [2:0]   interboard_sel_len = 3'd0;
   logic [3:0]   cur_game_state = ST;
   logic [4:0]   tbl_rd_x;
   logic [2:0]   tbl_rd_y;
   logic [5:0]   tbl_rd_card;
   logic         tbl_wr_en;
   logic [4:0]   tbl_wr_x;
   logic [2:0]   tbl_wr_y;
   logic [5:0]   tbl_wr_card;
   logic         remote_busy;
   logic         remote_shift_done;
   logic         remote_shift_err;
   logic [143:0] remote_sel_card;

   handle_remote_shift dut (
      .clk(clk), .rst(rst), .interboard_rst(interboard_rst),
      .interboard_en(interboard_en), .interboard_msg_type(interboard_msg_type),
      .interboard_move_dir(interboard_move_dir), .interboard_block_x(interboard_block_x),
      .interboard_block_y(interboard_block_y), .interboard_sel_len(interboard_sel_len),
      .cur_game_state(cur_game_state), .tbl_rd_x(tbl_rd_x), .tbl_rd_y(tbl_rd_y),
      .tbl_rd_card(tbl_rd_card), .tbl_wr_en(tbl_wr_en), .tbl_wr_x(tbl_wr_x),
      .tbl_wr_y(tbl_wr_y), .tbl_wr_card(tbl_wr_card), .remote_busy(remote_busy),
      .remote_shift_done(remote_shift_done), .remote_shift_err(remote_shift_err),
      .remote_sel_card(remote_sel_card)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int m_x = 0, m_y = 0, m_len = 0;

   logic [5:0] exp_tbl [0:7][0:17];
   logic [5:0] img     [0:7][0:17];
   logic [5:0] ram     [0:7][0:17];
   logic       load_req = 1'b0;
   logic [7:0] wr_hist [0:1023];
   int         wr_cnt = 0;

   // Table RAM seen by the DUT: combinational read, write on the clock edge.
   assign tbl_rd_card = (tbl_rd_x < 5'd18) ? ram[tbl_rd_y][tbl_rd_x] : EMPTY;

   always @(posedge clk) begin
      if (load_req) begin
         for (int y = 0; y < 8; y++)
            for (int x = 0; x < 18; x++)
               ram[y][x] <= img[y][x];
      end else if (tbl_wr_en) begin
         if (tbl_wr_x < 5'd18) ram[tbl_wr_y][tbl_wr_x] <= tbl_wr_card;
         wr_hist[wr_cnt % 1024] = {tbl_wr_y, tbl_wr_x};
         wr_cnt = wr_cnt + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [143:0] model_mask();
      logic [143:0] m;
      m = '0;
      if (m_len != 0) begin
         m = (144'd1 << m_len) - 144'd1;
         m = m << (m_y * 18 + m_x);
      end
      return m;
   endfunction

   function automatic int tbl_diffs();
      int n;
      n = 0;
      for (int y = 0; y < 8; y++)
         for (int x = 0; x < 18; x++)
            if (ram[y][x] !== exp_tbl[y][x]) n++;
      return n;
   endfunction

   task automatic load_table();
      for (int y = 0; y < 8; y++)
         for (int x = 0; x < 18; x++)
            img[y][x] = exp_tbl[y][x];
      load_req = 1'b1;
      step();
      load_req = 1'b0;
   endtask

   task automatic fill_table(input int pct_empty);
      for (int y = 0; y < 8; y++)
         for (int x = 0; x < 18; x++)
            exp_tbl[y][x] = (int'($urandom_range(99)) < pct_empty) ? EMPTY : 6'($urandom_range(62));
      load_table();
   endtask

   task automatic send(input logic [3:0] t, input logic d, input int x, input int y,
                       input int len, input logic [3:0] gs);
      interboard_msg_type = t;
      interboard_move_dir = d;
      interboard_block_x  = 5'(x);
      interboard_block_y  = 3'(y);
      interboard_sel_len  = 3'(len);
      cur_game_state      = gs;
      interboard_en       = 1'b1;
      step();
      interboard_en       = 1'b0;
   endtask

   task automatic do_sel(input int x, input int y, input int len, input logic [3:0] gs);
      logic valid, exp_e;
      valid = (len != 0) && (x + len - 1 <= 17);
      exp_e = (gs == ST) && !valid;
      send(T_SEL, 1'b0, x, y, len, gs);
      total++;
      if (remote_shift_err !== exp_e) begin
         bad++;
         $display("FAIL sel_err x=%0d len=%0d got=%b exp=%b", x, len, remote_shift_err, exp_e);
      end
      if (gs == ST && valid) begin
         m_x = x; m_y = y; m_len = len;
      end
      cur_game_state = ST;
      step();
      step();
      total++;
      if (remote_sel_card !== model_mask()) begin
         bad++;
         $display("FAIL sel_mask got=%h exp=%h", remote_sel_card, model_mask());
      end
   endtask

   task automatic do_done(input logic [3:0] gs);
      send(T_DON, 1'b0, 0, 0, 0, gs);
      if (gs == ST) m_len = 0;
      cur_game_state = ST;
      step();
      step();
      total++;
      if (remote_sel_card !== model_mask() || remote_shift_err !== 1'b0) begin
         bad++;
         $display("FAIL done_mask got=%h err=%b exp=%h", remote_sel_card, remote_shift_err, model_mask());
      end
   endtask

   task automatic do_move(input logic d, input logic [3:0] gs, input logic inject);
      int exp_done, exp_err, got_done, got_err, base, nw;
      logic ok, exp_busy, busy1, log_ok;
      logic [7:0] exp_w[$];
      logic [5:0] seg[$];
      ok = 1'b0; exp_done = -1; exp_err = -1; exp_busy = 1'b0;
      if (gs == ST) begin
         if (m_len == 0) exp_err = 1;
         else begin
            exp_busy = 1'b1;
            if (d) begin
               if (m_x + m_len <= 17) ok = (exp_tbl[m_y][m_x + m_len] == EMPTY);
            end else begin
               if (m_x > 0) ok = (exp_tbl[m_y][m_x - 1] == EMPTY);
            end
            if (ok) exp_done = m_len + 3; else exp_err = 2;
         end
      end
      if (ok) begin
         if (d) begin
            for (int i = m_len - 1; i >= 0; i--) exp_w.push_back({3'(m_y), 5'(m_x + i + 1)});
            exp_w.push_back({3'(m_y), 5'(m_x)});
         end else begin
            for (int i = 0; i < m_len; i++) exp_w.push_back({3'(m_y), 5'(m_x + i - 1)});
            exp_w.push_back({3'(m_y), 5'(m_x + m_len - 1)});
         end
         for (int i = 0; i < m_len; i++) seg.push_back(exp_tbl[m_y][m_x + i]);
         for (int i = 0; i < m_len; i++) exp_tbl[m_y][m_x + i] = EMPTY;
         m_x = d ? m_x + 1 : m_x - 1;
         for (int i = 0; i < m_len; i++) exp_tbl[m_y][m_x + i] = seg[i];
      end
      base = wr_cnt;
      send(T_MOV, d, $urandom_range(31), $urandom_range(7), $urandom_range(7), gs);
      cur_game_state = ST;
      busy1 = remote_busy;
      got_done = -1; got_err = -1;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         if (remote_shift_done && got_done < 0) got_done = cyc;
         if (remote_shift_err && got_err < 0) got_err = cyc;
         if (inject && cyc == 3) begin
            interboard_msg_type = T_MOV;
            interboard_en = 1'b1;
         end
         step();
         interboard_en = 1'b0;
      end
      nw = wr_cnt - base;
      log_ok = (nw == exp_w.size());
      if (log_ok)
         for (int k = 0; k < nw; k++)
            if (wr_hist[(base + k) % 1024] !== exp_w[k]) log_ok = 1'b0;
      total++;
      if (busy1 !== exp_busy) begin
         bad++;
         $display("FAIL move_busy got=%b exp=%b", busy1, exp_busy);
      end
      total++;
      if (got_done != exp_done) begin
         bad++;
         $display("FAIL move_done_cycle got=%0d exp=%0d", got_done, exp_done);
      end
      total++;
      if (got_err != exp_err) begin
         bad++;
         $display("FAIL move_err_cycle got=%0d exp=%0d", got_err, exp_err);
      end
      total++;
      if (!log_ok) begin
         bad++;
         $display("FAIL move_writes got_count=%0d exp_count=%0d", nw, exp_w.size());
      end
      total++;
      if (tbl_diffs() != 0) begin
         bad++;
         $display("FAIL move_table got_diffs=%0d exp_diffs=0", tbl_diffs());
      end
      total++;
      if (remote_sel_card !== model_mask() || remote_busy !== 1'b0) begin
         bad++;
         $display("FAIL move_mask got=%h busy=%b exp=%h", remote_sel_card, remote_busy, model_mask());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      m_x = 0; m_y = 0; m_len = 0;
      total++; if (remote_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", remote_busy); end
      total++; if (remote_shift_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", remote_shift_done); end
      total++; if (remote_shift_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", remote_shift_err); end
      total++; if (remote_sel_card !== '0) begin bad++; $display("FAIL rst_mask got=%h exp=0", remote_sel_card); end
      total++; if (tbl_wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%b exp=0", tbl_wr_en); end
      total++; if (tbl_rd_x !== 5'd0 || tbl_rd_y !== 3'd0) begin bad++; $display("FAIL rst_rd got=%0d,%0d exp=0,0", tbl_rd_x, tbl_rd_y); end
   endtask

   task automatic test_sel_and_right_move();
      for (int y = 0; y < 8; y++) for (int x = 0; x < 18; x++) exp_tbl[y][x] = EMPTY;
      exp_tbl[2][3] = 6'd10; exp_tbl[2][4] = 6'd11; exp_tbl[2][5] = 6'd12;
      load_table();
      do_sel(3, 2, 3, ST);
      total++;
      if (remote_sel_card !== (144'h7 << 39)) begin
         bad++;
         $display("FAIL sel_bits_39_41 got=%h exp=%h", remote_sel_card, 144'h7 << 39);
      end
      do_move(1'b1, ST, 1'b0);
      total++;
      if (remote_sel_card !== (144'h7 << 40)) begin
         bad++;
         $display("FAIL move_bits_40_42 got=%h exp=%h", remote_sel_card, 144'h7 << 40);
      end
   endtask

   task automatic test_left_blocked();
      do_sel(0, 2, 2, ST);
      do_move(1'b0, ST, 1'b0);
      exp_tbl[2][7] = 6'd20; exp_tbl[2][8] = 6'd30; exp_tbl[2][9] = 6'd31;
      load_table();
      do_sel(8, 2, 2, ST);
      do_move(1'b0, ST, 1'b0);
      exp_tbl[2][7] = EMPTY;
      load_table();
      do_move(1'b0, ST, 1'b0);
   endtask

   task automatic test_right_edge();
      exp_tbl[3][14] = 6'd1; exp_tbl[3][15] = 6'd2; exp_tbl[3][16] = 6'd3; exp_tbl[3][17] = EMPTY;
      load_table();
      do_sel(14, 3, 3, ST);
      do_move(1'b1, ST, 1'b0);
      do_move(1'b1, ST, 1'b0);
      do_sel(16, 3, 3, ST);
      do_sel(17, 3, 1, ST);
      do_sel(5, 3, 0, ST);
   endtask

   task automatic test_busy_gating();
      for (int x = 0; x < 18; x++) exp_tbl[4][x] = EMPTY;
      exp_tbl[4][5] = 6'd40; exp_tbl[4][6] = 6'd41; exp_tbl[4][7] = 6'd42; exp_tbl[4][8] = 6'd43;
      load_table();
      do_sel(5, 4, 4, ST);
      do_move(1'b1, ST, 1'b1);
      do_move(1'b0, 4'd3, 1'b0);
      do_sel(1, 1, 2, 4'd2);
      do_sel(30, 1, 5, 4'd2);
      do_done(4'd9);
   endtask

   task automatic test_reset_mid_move();
      int base;
      for (int x = 0; x < 18; x++) exp_tbl[6][x] = EMPTY;
      exp_tbl[6][2] = 6'd5; exp_tbl[6][3] = 6'd6; exp_tbl[6][4] = 6'd7; exp_tbl[6][5] = 6'd8;
      load_table();
      do_sel(2, 6, 4, ST);
      send(T_MOV, 1'b1, 0, 0, 0, ST);
      step();
      step();
      base = wr_cnt;
      interboard_rst = 1'b1;
      step();
      interboard_rst = 1'b0;
      m_x = 0; m_y = 0; m_len = 0;
      total++;
      if (remote_busy !== 1'b0 || remote_sel_card !== '0) begin
         bad++;
         $display("FAIL midrst_state got_busy=%b got_mask=%h exp=0,0", remote_busy, remote_sel_card);
      end
      for (int i = 0; i < 6; i++) step();
      total++;
      if (wr_cnt != base || remote_shift_done !== 1'b0) begin
         bad++;
         $display("FAIL midrst_writes got=%0d exp=0", wr_cnt - base);
      end
      fill_table(50);
   endtask

   task automatic test_done();
      do_sel(2, 1, 2, ST);
      do_done(ST);
      total++;
      if (remote_sel_card !== '0) begin
         bad++;
         $display("FAIL done_clear got=%h exp=0", remote_sel_card);
      end
      do_move(1'b1, ST, 1'b0);
   endtask

   task automatic test_random();
      int r;
      for (int it = 0; it < 60; it++) begin
         if (it % 8 == 0) fill_table(60);
         r = $urandom_range(9);
         if (r <= 2) do_sel($urandom_range(19), $urandom_range(7), $urandom_range(7), ST);
         else if (r <= 7) do_move(1'($urandom_range(1)), ST, 1'b0);
         else if (r == 8) do_done(ST);
         else do_move(1'($urandom_range(1)), 4'($urandom_range(4)), 1'b0);
      end
   endtask

   initial begin
      for (int y = 0; y < 8; y++) for (int x = 0; x < 18; x++) exp_tbl[y][x] = EMPTY;
      load_table();
      test_reset();
      test_sel_and_right_move();
      test_left_blocked();
      test_right_edge();
      test_busy_gating();
      test_reset_mid_move();
      test_done();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
